// File: rtl/stream_frame_source.sv
// Transmit-side framer: packs n*p 16-bit elements into one wide beat and
// emits a message of cfg_len beats on a valid/ready stream with start/last framing.
module stream_frame_source #(
    parameter int n     = 4,
    parameter int p     = 1,
    parameter int LEN_W = 16
) (
    input  logic                 aclk,
    input  logic                 reset,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic                 cfg_load,
    output logic                 busy,
    input  logic [15:0]          edata,
    input  logic                 evalid,
    output logic                 eready,
    output logic [16*p*n-1:0]    odata,
    output logic                 ovalid,
    input  logic                 oready,
    output logic                 ostart,
    output logic                 olast
);

    localparam int SLOTS = n * p;
    localparam int W     = 16 * SLOTS;
    localparam int CW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    elem_cnt;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] len;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // eready/ovalid depend only on state, so they never combinationally follow the inputs.
    assign busy   = (state != IDLE);
    assign eready = (state == FILL);
    assign ovalid = (state == SEND);
    assign ostart = ovalid && (beat_cnt == '0);
    assign olast  = ovalid && (beat_cnt == len - LEN_W'(1));

    always_ff @(posedge aclk) begin
        if (reset) begin
            state    <= IDLE;
            elem_cnt <= '0;
            beat_cnt <= '0;
            len      <= '0;
            odata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_load && (cfg_len != '0)) begin
                        len      <= cfg_len;
                        beat_cnt <= '0;
                        elem_cnt <= '0;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (evalid) begin
                        // Slots fill MSB-first: slot e is lane e%p, operand e/p.
                        odata[W-1-16*int'(elem_cnt) -: 16] <= edata;
                        if (elem_cnt == CW'(SLOTS - 1)) begin
                            elem_cnt <= '0;
                            state    <= SEND;
                        end else begin
                            elem_cnt <= elem_cnt + CW'(1);
                        end
                    end
                end
                SEND: begin
                    if (oready) begin
                        if (olast) begin
                            state <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + LEN_W'(1);
                            state    <= FILL;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_frame_source.sv
// Directed bench for stream_frame_source: n=4/p=1 instance for framing,
// backpressure, config and reset cases; n=2/p=2 instance for lane ordering.
module tb_stream_frame_source;

    logic        aclk = 1'b0;
    logic        reset;
    logic [15:0] cfg_len;
    logic        cfg_load;
    logic        busy;
    logic [15:0] edata;
    logic        evalid;
    logic        eready;
    logic [63:0] odata;
    logic        ovalid;
    logic        oready;
    logic        ostart;
    logic        olast;

    logic [15:0] b_cfg_len;
    logic        b_cfg_load;
    logic        b_busy;
    logic [15:0] b_edata;
    logic        b_evalid;
    logic        b_eready;
    logic [63:0] b_odata;
    logic        b_ovalid;
    logic        b_oready;
    logic        b_ostart;
    logic        b_olast;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    always #5 aclk = ~aclk;

    stream_frame_source #(.n(4), .p(1), .LEN_W(16)) dut (
        .aclk(aclk), .reset(reset), .cfg_len(cfg_len), .cfg_load(cfg_load),
        .busy(busy), .edata(edata), .evalid(evalid), .eready(eready),
        .odata(odata), .ovalid(ovalid), .oready(oready), .ostart(ostart), .olast(olast)
    );

    stream_frame_source #(.n(2), .p(2), .LEN_W(16)) dut2 (
        .aclk(aclk), .reset(reset), .cfg_len(b_cfg_len), .cfg_load(b_cfg_load),
        .busy(b_busy), .edata(b_edata), .evalid(b_evalid), .eready(b_eready),
        .odata(b_odata), .ovalid(b_ovalid), .oready(b_oready), .ostart(b_ostart), .olast(b_olast)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] l);
        cfg_len  = l;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    // Presents one element and returns after the edge that accepted it.
    task automatic put(input logic [15:0] d);
        int k;
        edata  = d;
        evalid = 1'b1;
        k = 0;
        while (!eready && k < 50) begin
            tick();
            k++;
        end
        if (k == 50) chk("put_timeout", 64'd1, 64'd0);
        tick();
        evalid = 1'b0;
    endtask

    // Waits for a beat, compares it against the scoreboard head, then takes it.
    task automatic take(input string tag, input logic exp_start, input logic exp_last);
        int k;
        logic [63:0] exp_d;
        k = 0;
        while (!ovalid && k < 50) begin
            tick();
            k++;
        end
        if (k == 50) chk({tag, "_timeout"}, 64'd1, 64'd0);
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        chk({tag, "_odata"}, odata, exp_d);
        chk({tag, "_ostart"}, 64'(ostart), 64'(exp_start));
        chk({tag, "_olast"}, 64'(olast), 64'(exp_last));
        chk({tag, "_eready"}, 64'(eready), 64'd0);
        oready = 1'b1;
        tick();
        oready = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cfg_len = '0; cfg_load = 1'b0; edata = '0; evalid = 1'b0; oready = 1'b0;
        b_cfg_len = '0; b_cfg_load = 1'b0; b_edata = '0; b_evalid = 1'b0; b_oready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_eready", 64'(eready), 64'd0);
        chk("rst_ovalid", 64'(ovalid), 64'd0);
        chk("rst_ostart", 64'(ostart), 64'd0);
        chk("rst_olast", 64'(olast), 64'd0);
        chk("rst_odata", odata, 64'd0);

        // Single-beat message: ovalid one cycle after the 4th element.
        load(16'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_eready", 64'(eready), 64'd1);
        put(16'h0001); put(16'h0002); put(16'h0003);
        chk("t1_no_ovalid_early", 64'(ovalid), 64'd0);
        put(16'h0004);
        chk("t1_ovalid_latency", 64'(ovalid), 64'd1);
        exp_q.push_back(64'h0001_0002_0003_0004);
        take("t1", 1'b1, 1'b1);
        chk("t1_busy_after", 64'(busy), 64'd0);
        chk("t1_ovalid_after", 64'(ovalid), 64'd0);

        // Three-beat message with framing on first and last beats only.
        load(16'd3);
        exp_q.push_back(64'h0001_0002_0003_0004);
        exp_q.push_back(64'h0005_0006_0007_0008);
        exp_q.push_back(64'h0009_000A_000B_000C);
        for (int b = 0; b < 3; b++) begin
            for (int e = 0; e < 4; e++) put(16'(b * 4 + e + 1));
            take($sformatf("t2_beat%0d", b), b == 0, b == 2);
            if (b < 2) chk($sformatf("t2_busy%0d", b), 64'(busy), 64'd1);
        end
        chk("t2_busy_end", 64'(busy), 64'd0);

        // Backpressure: 10 cycles of oready=0 with evalid held high.
        load(16'd1);
        put(16'h0011); put(16'h0012); put(16'h0013); put(16'h0014);
        edata  = 16'hDEAD;
        evalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("t3_ovalid", 64'(ovalid), 64'd1);
            chk("t3_odata", odata, 64'h0011_0012_0013_0014);
            chk("t3_ostart", 64'(ostart), 64'd1);
            chk("t3_olast", 64'(olast), 64'd1);
            chk("t3_eready", 64'(eready), 64'd0);
            tick();
        end
        evalid = 1'b0;
        exp_q.push_back(64'h0011_0012_0013_0014);
        take("t3", 1'b1, 1'b1);
        chk("t3_busy_end", 64'(busy), 64'd0);

        // n=2, p=2 with gapped evalid: slots run lane0op0, lane1op0, lane0op1, lane1op1.
        b_cfg_len  = 16'd1;
        b_cfg_load = 1'b1;
        tick();
        b_cfg_load = 1'b0;
        for (int e = 0; e < 4; e++) begin
            chk($sformatf("t4_eready%0d", e), 64'(b_eready), 64'd1);
            b_edata  = 16'hA0A0 + 16'(e);
            b_evalid = 1'b1;
            tick();
            b_evalid = 1'b0;
            b_edata  = 16'hFFFF;
            if (e < 3) begin
                chk($sformatf("t4_no_ovalid%0d", e), 64'(b_ovalid), 64'd0);
                tick();
                chk($sformatf("t4_gap_ovalid%0d", e), 64'(b_ovalid), 64'd0);
            end
        end
        chk("t4_ovalid", 64'(b_ovalid), 64'd1);
        chk("t4_odata", b_odata, 64'hA0A0_A0A1_A0A2_A0A3);
        chk("t4_framing", 64'({b_ostart, b_olast}), 64'd3);
        b_oready = 1'b1;
        tick();
        b_oready = 1'b0;
        chk("t4_busy_end", 64'(b_busy), 64'd0);

        // Config edge cases: zero length ignored; reload mid-message ignored.
        load(16'd0);
        chk("t5_len0_busy", 64'(busy), 64'd0);
        load(16'd2);
        load(16'd5);
        exp_q.push_back(64'h0101_0102_0103_0104);
        exp_q.push_back(64'h0201_0202_0203_0204);
        put(16'h0101); put(16'h0102); put(16'h0103); put(16'h0104);
        take("t5_beat0", 1'b1, 1'b0);
        put(16'h0201); put(16'h0202); put(16'h0203); put(16'h0204);
        cfg_len  = 16'd3;
        cfg_load = 1'b1;
        take("t5_beat1", 1'b0, 1'b1);
        cfg_load = 1'b0;
        chk("t5_busy_end", 64'(busy), 64'd0);
        tick();
        chk("t5_busy_stay_idle", 64'(busy), 64'd0);

        // Reset after 2 of 4 elements of the second beat.
        load(16'd2);
        exp_q.push_back(64'h0301_0302_0303_0304);
        put(16'h0301); put(16'h0302); put(16'h0303); put(16'h0304);
        take("t6_beat0", 1'b1, 1'b0);
        put(16'h0401); put(16'h0402);
        reset = 1'b1;
        tick();
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_eready", 64'(eready), 64'd0);
        chk("t6_ovalid", 64'(ovalid), 64'd0);
        chk("t6_framing", 64'({ostart, olast}), 64'd0);
        chk("t6_odata", odata, 64'd0);
        reset = 1'b0;
        load(16'd1);
        put(16'h0021); put(16'h0022); put(16'h0023); put(16'h0024);
        exp_q.push_back(64'h0021_0022_0023_0024);
        take("t6_new", 1'b1, 1'b1);
        chk("t6_busy_end", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
